// File: rtl/rx_sample_sequencer_pkg.sv
// Shared definitions for the RX sample sequencer: FSM state encoding,
// words written per channel per sample, and helpers deriving the
// half-buffer (H) and full-buffer (2H) sizes from the block parameters.
package rx_sample_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_Q = 2'd2,
    RD_P = 2'd3
  } seq_state_t;

  localparam int WORDS_PER_SAMP = 3;

  localparam int DEF_RX_CHANS = 4;
  localparam int DEF_NSAMPS   = 170;
  localparam int DEF_AW       = 12;

  // H: words in one half of the double-buffered sample RAM
  function automatic int half_words(input int nsamps, input int chans);
    return nsamps * chans * WORDS_PER_SAMP;
  endfunction

  // 2H: words in the whole sample RAM, the write-pointer modulus
  function automatic int buf_words(input int nsamps, input int chans);
    return 2 * half_words(nsamps, chans);
  endfunction

endpackage

// File: rtl/rx_sample_sequencer_if.sv
// Channel read-mux and sample-buffer write port of the sequencer.
// The master side (sequencer) drives selects and buffer writes and
// receives the muxed channel word; the slave side is the datapath/RAM.
interface rx_sample_sequencer_if
  import rx_sample_sequencer_pkg::*;
#(
  parameter int RX_CHANS = DEF_RX_CHANS,
  parameter int AW       = DEF_AW
) ();

  logic [RX_CHANS-1:0] rx_sel;
  logic                rd_i;
  logic                rd_q;
  logic [15:0]         rx_din;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [15:0]         wr_data;
  logic                buf_ready;
  logic                buf_half;

  modport master (
    output rx_sel, rd_i, rd_q, wr_en, wr_addr, wr_data, buf_ready, buf_half,
    input  rx_din
  );

  modport slave (
    input  rx_sel, rd_i, rd_q, wr_en, wr_addr, wr_data, buf_ready, buf_half,
    output rx_din
  );

endinterface

// File: rtl/rx_seq_ptr.sv
// Sample-buffer write pointer: counts modulo 2H (not 2^AW) and flags
// when it sits on the last word of either half.
module rx_seq_ptr
  import rx_sample_sequencer_pkg::*;
#(
  parameter int RX_CHANS = DEF_RX_CHANS,
  parameter int NSAMPS   = DEF_NSAMPS,
  parameter int AW       = DEF_AW
) (
  input  logic          adc_clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          inc,
  output logic [AW-1:0] ptr,
  output logic          last_h0,
  output logic          last_h1
);

  localparam logic [AW-1:0] LAST0 = AW'(half_words(NSAMPS, RX_CHANS) - 1);
  localparam logic [AW-1:0] LAST1 = AW'(buf_words(NSAMPS, RX_CHANS) - 1);

  // Advance after every buffer write, wrapping at 2H; clear restarts at 0
  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST1) ? '0 : ptr + AW'(1);
    end
  end

  assign last_h0 = (ptr == LAST0);
  assign last_h1 = (ptr == LAST1);

endmodule

// File: rtl/rx_sample_sequencer.sv
// Walks all RX channels on each decimated-sample strobe, reading I, Q and
// the packed word of each channel into the double-buffered sample RAM.
// Signals half-buffer completion and flags strobes that arrive mid-burst.
module rx_sample_sequencer
  import rx_sample_sequencer_pkg::*;
#(
  parameter int RX_CHANS = DEF_RX_CHANS,
  parameter int NSAMPS   = DEF_NSAMPS,
  parameter int AW       = DEF_AW
) (
  input  logic                 adc_clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 rx_avail,
  input  logic                 ovr_clr,
  output logic                 overrun,
  rx_sample_sequencer_if.master bus
);

  localparam int              CH_W    = (RX_CHANS > 1) ? $clog2(RX_CHANS) : 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(RX_CHANS - 1);

  seq_state_t          state, state_next;
  logic [CH_W-1:0]     ch, ch_next;
  logic [RX_CHANS-1:0] sel_next, rx_sel_q;
  logic                rd_i_next, rd_q_next, wr_en_next;
  logic                rd_i_q, rd_q_q, wr_en_q;
  logic                enable_d;
  logic                ptr_clear, ovr_set;
  logic                last_h0, last_h1;
  logic                buf_ready_q, buf_half_q;
  logic [AW-1:0]       ptr;

  assign ptr_clear = enable && !enable_d && (state == IDLE);
  assign ovr_set   = rx_avail && enable && (state != IDLE);

  rx_seq_ptr #(
    .RX_CHANS (RX_CHANS),
    .NSAMPS   (NSAMPS),
    .AW       (AW)
  ) u_ptr (
    .adc_clk (adc_clk),
    .reset_n (reset_n),
    .clear   (ptr_clear),
    .inc     (wr_en_q),
    .ptr     (ptr),
    .last_h0 (last_h0),
    .last_h1 (last_h1)
  );

  // Next state/channel, and the read/write controls that state will drive
  always_comb begin
    state_next = state;
    ch_next    = ch;
    case (state)
      IDLE: begin
        if (rx_avail && enable) begin
          state_next = RD_I;
          ch_next    = '0;
        end
      end
      RD_I: state_next = RD_Q;
      RD_Q: state_next = RD_P;
      RD_P: begin
        if (ch == CH_LAST) begin
          state_next = IDLE;
        end else begin
          state_next = RD_I;
          ch_next    = ch + CH_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    wr_en_next = (state_next != IDLE);
    rd_i_next  = (state_next == RD_I);
    rd_q_next  = (state_next == RD_Q);
    sel_next   = wr_en_next ? (RX_CHANS'(1) << ch_next) : '0;
  end

  // State, channel and registered mux/write controls
  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ch       <= '0;
      rx_sel_q <= '0;
      rd_i_q   <= 1'b0;
      rd_q_q   <= 1'b0;
      wr_en_q  <= 1'b0;
    end else begin
      state    <= state_next;
      ch       <= ch_next;
      rx_sel_q <= sel_next;
      rd_i_q   <= rd_i_next;
      rd_q_q   <= rd_q_next;
      wr_en_q  <= wr_en_next;
    end
  end

  // Enable history, sticky overrun (set beats clear), half-buffer pulse
  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_d    <= 1'b0;
      overrun     <= 1'b0;
      buf_ready_q <= 1'b0;
      buf_half_q  <= 1'b0;
    end else begin
      enable_d <= enable;
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
      buf_ready_q <= wr_en_q && (last_h0 || last_h1);
      if (wr_en_q && (last_h0 || last_h1)) begin
        buf_half_q <= last_h1;
      end
    end
  end

  assign bus.rx_sel    = rx_sel_q;
  assign bus.rd_i      = rd_i_q;
  assign bus.rd_q      = rd_q_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = ptr;
  assign bus.wr_data   = bus.rx_din;
  assign bus.buf_ready = buf_ready_q;
  assign bus.buf_half  = buf_half_q;

endmodule

// File: tb/tb_rx_sample_sequencer.sv
// Scoreboard bench for rx_sample_sequencer. Main instance: RX_CHANS=2,
// NSAMPS=4 (H=24). Second instance: RX_CHANS=1, NSAMPS=2 (H=6) driven at
// the minimum strobe spacing. Stimulus pushes expected writes and
// half-buffer pulses; monitors pop and compare when the DUT presents them.
module tb_rx_sample_sequencer;
  import rx_sample_sequencer_pkg::*;

  localparam int RXC  = 2;
  localparam int NS   = 4;
  localparam int AWB  = 6;
  localparam int HW   = NS * RXC * WORDS_PER_SAMP;
  localparam int SPAN = RXC * WORDS_PER_SAMP;

  localparam int RXC2 = 1;
  localparam int NS2  = 2;
  localparam int AWB2 = 4;
  localparam int HW2  = NS2 * RXC2 * WORDS_PER_SAMP;

  typedef struct {
    int cyc;
    int addr;
    int sel;
    int ri;
    int rq;
    int data;
  } wr_t;

  typedef struct {
    int cyc;
    int half;
  } rdy_t;

  logic adc_clk   = 1'b0;
  logic reset_n   = 1'b0;
  logic enable    = 1'b0;
  logic rx_avail  = 1'b0;
  logic ovr_clr   = 1'b0;
  logic overrun;
  logic enable2   = 1'b1;
  logic rx_avail2 = 1'b0;
  logic ovr_clr2  = 1'b0;
  logic overrun2;

  int         cyc        = 0;
  int         n_cmp      = 0;
  int         n_bad      = 0;
  int         exp_ptr    = 0;
  int         exp_ptr2   = 0;
  int         busy_until = 0;
  logic       exp_ovr    = 1'b0;
  logic [7:0] tag        = 8'd0;
  logic [7:0] tag2       = 8'd0;

  wr_t  exp_q[$];
  wr_t  exp_q2[$];
  rdy_t rdy_q[$];
  rdy_t rdy_q2[$];

  rx_sample_sequencer_if #(.RX_CHANS(RXC),  .AW(AWB))  bus  ();
  rx_sample_sequencer_if #(.RX_CHANS(RXC2), .AW(AWB2)) bus2 ();

  rx_sample_sequencer #(.RX_CHANS(RXC), .NSAMPS(NS), .AW(AWB)) dut (
    .adc_clk  (adc_clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .rx_avail (rx_avail),
    .ovr_clr  (ovr_clr),
    .overrun  (overrun),
    .bus      (bus)
  );

  rx_sample_sequencer #(.RX_CHANS(RXC2), .NSAMPS(NS2), .AW(AWB2)) dut2 (
    .adc_clk  (adc_clk),
    .reset_n  (reset_n),
    .enable   (enable2),
    .rx_avail (rx_avail2),
    .ovr_clr  (ovr_clr2),
    .overrun  (overrun2),
    .bus      (bus2)
  );

  always #5 adc_clk = ~adc_clk;

  always @(posedge adc_clk) cyc <= cyc + 1;

  // Channel mux model: word identifies sample tag, selected channel and kind
  function automatic logic [15:0] dinOf(input int sel, input logic ri, input logic rq,
                                        input logic [7:0] tag_v);
    return {tag_v, sel[3:0], ri, rq, 2'b10};
  endfunction

  assign bus.rx_din  = dinOf(int'(bus.rx_sel),  bus.rd_i,  bus.rd_q,  tag);
  assign bus2.rx_din = dinOf(int'(bus2.rx_sel), bus2.rd_i, bus2.rd_q, tag2);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Expected writes and half pulses for one accepted strobe on the main DUT
  task automatic pushBurst();
    wr_t  e;
    logic ri, rq;
    tag++;
    for (int i = 0; i < SPAN; i++) begin
      ri     = ((i % WORDS_PER_SAMP) == 0);
      rq     = ((i % WORDS_PER_SAMP) == 1);
      e.cyc  = cyc + 1 + i;
      e.addr = exp_ptr;
      e.sel  = 1 << (i / WORDS_PER_SAMP);
      e.ri   = int'(ri);
      e.rq   = int'(rq);
      e.data = int'(dinOf(e.sel, ri, rq, tag));
      exp_q.push_back(e);
      if (exp_ptr == HW - 1)     rdy_q.push_back('{cyc + 2 + i, 0});
      if (exp_ptr == 2 * HW - 1) rdy_q.push_back('{cyc + 2 + i, 1});
      exp_ptr = (exp_ptr + 1) % (2 * HW);
    end
  endtask

  // One cycle of main-DUT inputs; also checks overrun against the model
  task automatic applyStimulus(input logic avail, input logic clr, input logic en);
    logic set_now;
    @(posedge adc_clk);
    #1;
    checkOutput("overrun", 32'(overrun), 32'(exp_ovr));
    if (en && !enable && cyc >= busy_until) exp_ptr = 0;
    enable   = en;
    rx_avail = avail;
    ovr_clr  = clr;
    set_now  = 1'b0;
    if (avail && en) begin
      if (cyc >= busy_until) begin
        busy_until = cyc + SPAN + 1;
        pushBurst();
      end else begin
        set_now = 1'b1;
      end
    end
    if (set_now) exp_ovr = 1'b1;
    else if (clr) exp_ovr = 1'b0;
  endtask

  // Main DUT monitor
  always @(negedge adc_clk) begin
    wr_t  e;
    rdy_t r;
    if (reset_n) begin
      if (bus.wr_en) begin
        if (exp_q.size() == 0) begin
          checkOutput("stray_write", 32'(bus.wr_en), 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("wr_cycle", cyc, e.cyc);
          checkOutput("wr_addr", 32'(bus.wr_addr), e.addr);
          checkOutput("rx_sel", 32'(bus.rx_sel), e.sel);
          checkOutput("rd_i", 32'(bus.rd_i), e.ri);
          checkOutput("rd_q", 32'(bus.rd_q), e.rq);
          checkOutput("wr_data", 32'(bus.wr_data), e.data);
        end
      end else begin
        checkOutput("idle_rx_sel", 32'(bus.rx_sel), 32'd0);
      end
      if (bus.buf_ready) begin
        if (rdy_q.size() == 0) begin
          checkOutput("stray_buf_ready", 32'(bus.buf_ready), 32'd0);
        end else begin
          r = rdy_q.pop_front();
          checkOutput("buf_ready_cycle", cyc, r.cyc);
          checkOutput("buf_half", 32'(bus.buf_half), r.half);
        end
      end
    end
  end

  // Single-channel DUT monitor
  always @(negedge adc_clk) begin
    wr_t  e;
    rdy_t r;
    if (reset_n) begin
      if (bus2.wr_en) begin
        if (exp_q2.size() == 0) begin
          checkOutput("stray_write2", 32'(bus2.wr_en), 32'd0);
        end else begin
          e = exp_q2.pop_front();
          checkOutput("wr_cycle2", cyc, e.cyc);
          checkOutput("wr_addr2", 32'(bus2.wr_addr), e.addr);
          checkOutput("rx_sel2", 32'(bus2.rx_sel), e.sel);
          checkOutput("rd_i2", 32'(bus2.rd_i), e.ri);
          checkOutput("rd_q2", 32'(bus2.rd_q), e.rq);
          checkOutput("wr_data2", 32'(bus2.wr_data), e.data);
        end
      end
      if (bus2.buf_ready) begin
        if (rdy_q2.size() == 0) begin
          checkOutput("stray_buf_ready2", 32'(bus2.buf_ready), 32'd0);
        end else begin
          r = rdy_q2.pop_front();
          checkOutput("buf_ready_cycle2", cyc, r.cyc);
          checkOutput("buf_half2", 32'(bus2.buf_half), r.half);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    wr_t  e2;
    logic ri2, rq2;

    // Reset state
    repeat (3) @(posedge adc_clk);
    #1;
    checkOutput("rst_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("rst_rx_sel", 32'(bus.rx_sel), 32'd0);
    checkOutput("rst_rd_i", 32'(bus.rd_i), 32'd0);
    checkOutput("rst_rd_q", 32'(bus.rd_q), 32'd0);
    checkOutput("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("rst_buf_ready", 32'(bus.buf_ready), 32'd0);
    checkOutput("rst_buf_half", 32'(bus.buf_half), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Nine strobes 10 cycles apart: fills half 0, half 1, then wraps to 0
    for (int s = 0; s < 9; s++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (9) applyStimulus(1'b0, 1'b0, 1'b1);
      if (s == 3) checkOutput("buf_half_hold0", 32'(bus.buf_half), 32'd0);
      if (s == 7) checkOutput("buf_half_hold1", 32'(bus.buf_half), 32'd1);
    end

    // Strobe 3 cycles into a burst is dropped and flags overrun
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);

    // Clear coincident with a new overrun strobe: overrun stays set
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);

    // Enable dropped mid-burst; strobes while disabled do nothing
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

    // Re-enable restarts the buffer at address 0
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (9) applyStimulus(1'b0, 1'b0, 1'b1);

    // Asynchronous reset three cycles into a burst
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(posedge adc_clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("arst_rx_sel", 32'(bus.rx_sel), 32'd0);
    checkOutput("arst_rd_i", 32'(bus.rd_i), 32'd0);
    checkOutput("arst_rd_q", 32'(bus.rd_q), 32'd0);
    checkOutput("arst_wr_addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("arst_buf_ready", 32'(bus.buf_ready), 32'd0);
    checkOutput("arst_overrun", 32'(overrun), 32'd0);
    exp_q.delete();
    rdy_q.delete();
    exp_ptr    = 0;
    busy_until = 0;
    exp_ovr    = 1'b0;
    repeat (3) @(posedge adc_clk);
    #2;
    reset_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (9) applyStimulus(1'b0, 1'b0, 1'b1);

    // Single-channel instance at minimum strobe spacing (4 cycles)
    for (int s = 0; s < 8; s++) begin
      @(posedge adc_clk);
      #1;
      checkOutput("overrun2", 32'(overrun2), 32'd0);
      rx_avail2 = 1'b1;
      tag2++;
      for (int i = 0; i < 3; i++) begin
        ri2     = (i == 0);
        rq2     = (i == 1);
        e2.cyc  = cyc + 1 + i;
        e2.addr = exp_ptr2;
        e2.sel  = 1;
        e2.ri   = int'(ri2);
        e2.rq   = int'(rq2);
        e2.data = int'(dinOf(1, ri2, rq2, tag2));
        exp_q2.push_back(e2);
        if (exp_ptr2 == HW2 - 1)     rdy_q2.push_back('{cyc + 2 + i, 0});
        if (exp_ptr2 == 2 * HW2 - 1) rdy_q2.push_back('{cyc + 2 + i, 1});
        exp_ptr2 = (exp_ptr2 + 1) % (2 * HW2);
      end
      @(posedge adc_clk);
      #1;
      rx_avail2 = 1'b0;
      repeat (2) @(posedge adc_clk);
    end
    repeat (6) @(posedge adc_clk);
    #1;
    checkOutput("overrun2_final", 32'(overrun2), 32'd0);

    // Every expected write and half pulse must have been seen
    checkOutput("pending_writes", exp_q.size(), 0);
    checkOutput("pending_ready", rdy_q.size(), 0);
    checkOutput("pending_writes2", exp_q2.size(), 0);
    checkOutput("pending_ready2", rdy_q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
